fdct_butterfly: RTL and testbench

Pipelined, multi-lane signed butterfly for the FDCT datapath. For each lane it produces sum `a+b` and difference `a-b` of two signed samples together, exact at WIDTH+1 bits, with optional rounding right-shift and per-transaction saturation back to WIDTH bits. It sits between the row/column sample buffers and the constant-multiply stages. A valid/ready handshake with full-throughput backpressure lets it be chained directly.

---
 rtl/fdct_butterfly.sv | 99 +++++++++
 tb/tb_fdct_butterfly.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fdct_butterfly.sv
// fdct_butterfly: two-stage multi-lane signed sum/difference butterfly with rounding shift and optional saturation
module fdct_butterfly #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sat,
  input  logic [LANES*WIDTH-1:0]   in_a,
  input  logic [LANES*WIDTH-1:0]   in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*(WIDTH+1)-1:0] out_sum,
  output logic [LANES*(WIDTH+1)-1:0] out_diff,
  output logic [2*LANES-1:0]       out_flag
);
  localparam int W2 = WIDTH + 2;
  localparam int OW = WIDTH + 1;
  localparam logic signed [W2-1:0] RND = W2'((1 << SHIFT) >> 1);
  localparam logic signed [W2-1:0] HI  = W2'((1 << (WIDTH-1)) - 1);
  localparam logic signed [W2-1:0] LO  = ~HI;

  logic s1_v_q, s1_v_d, s1_sat_q, s1_sat_d, s2_v_q, s2_v_d;
  logic [LANES-1:0][W2-1:0] s1_sum_q, s1_sum_d, s1_diff_q, s1_diff_d;
  logic [LANES*OW-1:0] sum_q, sum_d, diff_q, diff_d;
  logic [2*LANES-1:0] flag_q, flag_d;
  logic [OW:0] ps, pd;
  logic s2_adv, s1_adv, load1, load2;

  function automatic logic [W2-1:0] ext(input logic [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // returns {clamped, value}; WIDTH+2 headroom means rounding cannot overflow
  function automatic logic [OW:0] post(input logic [W2-1:0] x, input logic sat);
    logic signed [W2-1:0] r;
    r = (signed'(x) + RND) >>> SHIFT;
    return (sat && r > HI) ? {1'b1, HI[OW-1:0]} :
           (sat && r < LO) ? {1'b1, LO[OW-1:0]} : {1'b0, r[OW-1:0]};
  endfunction

  assign s2_adv    = !s2_v_q || out_ready;
  assign s1_adv    = !s1_v_q || s2_adv;
  assign in_ready  = rst_n && s1_adv;
  assign load1     = s1_adv && in_valid;
  assign load2     = s2_adv && s1_v_q;
  assign out_valid = rst_n && s2_v_q;
  assign out_sum   = sum_q;
  assign out_diff  = diff_q;
  assign out_flag  = flag_q;

  always_comb begin
    s1_v_d    = s1_adv ? in_valid : s1_v_q;
    s1_sat_d  = load1 ? in_sat : s1_sat_q;
    s2_v_d    = s2_adv ? s1_v_q : s2_v_q;
    s1_sum_d  = s1_sum_q;
    s1_diff_d = s1_diff_q;
    sum_d     = sum_q;
    diff_d    = diff_q;
    flag_d    = flag_q;
    ps        = '0;
    pd        = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_sum_d[i]  = load1 ? ext(in_a[i*WIDTH +: WIDTH]) + ext(in_b[i*WIDTH +: WIDTH]) : s1_sum_q[i];
      s1_diff_d[i] = load1 ? ext(in_a[i*WIDTH +: WIDTH]) - ext(in_b[i*WIDTH +: WIDTH]) : s1_diff_q[i];
      ps = post(s1_sum_q[i], s1_sat_q);
      pd = post(s1_diff_q[i], s1_sat_q);
      sum_d[i*OW +: OW]  = load2 ? ps[OW-1:0] : sum_q[i*OW +: OW];
      diff_d[i*OW +: OW] = load2 ? pd[OW-1:0] : diff_q[i*OW +: OW];
      flag_d[2*i]        = load2 ? ps[OW] : flag_q[2*i];
      flag_d[2*i+1]      = load2 ? pd[OW] : flag_q[2*i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_sat_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_sum_q  <= '0;
      s1_diff_q <= '0;
      sum_q     <= '0;
      diff_q    <= '0;
      flag_q    <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sat_q  <= s1_sat_d;
      s2_v_q    <= s2_v_d;
      s1_sum_q  <= s1_sum_d;
      s1_diff_q <= s1_diff_d;
      sum_q     <= sum_d;
      diff_q    <= diff_d;
      flag_q    <= flag_d;
    end
  end
endmodule

// File: tb/tb_fdct_butterfly.sv
// tb_fdct_butterfly: directed vectors on SHIFT=0 and SHIFT=1 instances plus handshake/reset sequences
module tb_fdct_butterfly;
  localparam int W = 8;
  localparam int L = 4;

  logic clk = 0, rst_n = 0, in_valid = 0, in_sat = 0, out_ready = 1;
  logic [L*W-1:0] in_a = '0, in_b = '0;
  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic [L*(W+1)-1:0] sum0, diff0, sum1, diff1;
  logic [2*L-1:0] flag0, flag1;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  fdct_butterfly #(.WIDTH(W), .LANES(L), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_sat(in_sat),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(sum0), .out_diff(diff0), .out_flag(flag0));

  fdct_butterfly #(.WIDTH(W), .LANES(L), .SHIFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_sat(in_sat),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(sum1), .out_diff(diff1), .out_flag(flag1));

  typedef struct {
    int a0, b0, a1, b1;
    bit sat, sh;
    int s0, d0, s1, d1, fl;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ln(input logic [L*(W+1)-1:0] v, input int i);
    logic signed [W:0] t;
    t = v[i*(W+1) +: W+1];
    return int'(t);
  endfunction

  task automatic drive(input int a0, input int b0, input int a1, input int b1, input bit sat);
    in_a = '0;
    in_b = '0;
    in_a[0 +: W] = W'(a0);
    in_a[W +: W] = W'(a1);
    in_b[0 +: W] = W'(b0);
    in_b[W +: W] = W'(b1);
    in_sat = sat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tv[9];
    bit pat[6];
    bit m1, m2, s1a, s2a, stalled;
    int tx, rx, stall_seen;
    logic [L*(W+1)-1:0] held;

    tv[0] = '{100, 50, -128, 127, 0, 0, 150, 50, -1, -255, 0};
    tv[1] = '{100, 50, -128, 127, 1, 0, 127, 50, -1, -128, 9};
    tv[2] = '{-128, -128, 127, 127, 0, 0, -256, 0, 254, 0, 0};
    tv[3] = '{-128, -128, 127, 127, 1, 0, -128, 0, 127, 0, 5};
    tv[4] = '{-1, 1, 5, -7, 1, 0, 0, -2, -2, 12, 0};
    tv[5] = '{3, 0, -3, 0, 0, 1, 2, 2, -1, -1, 0};
    tv[6] = '{127, -128, 0, 0, 0, 1, 0, 128, 0, 0, 0};
    tv[7] = '{127, -128, 0, 0, 1, 1, 0, 127, 0, 0, 2};
    tv[8] = '{-128, 127, -128, -128, 1, 1, 0, -127, -128, 0, 0};
    pat = '{0, 0, 1, 0, 1, 1};

    // reset held with in_valid high
    in_valid = 1;
    drive(10, 3, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_in_ready", int'(in_ready0), 0);
      chk("rst_out_valid", int'(out_valid0), 0);
      if (c > 0) chk("rst_out_sum", int'(sum0 | diff0), 0);
    end
    rst_n = 1;
    #1 chk("release_in_ready", int'(in_ready0), 1);
    @(posedge clk); #1 in_valid = 0;
    chk("first_out_valid_early", int'(out_valid0), 0);
    @(posedge clk); #1;
    chk("first_out_valid", int'(out_valid0), 1);
    chk("first_sum", ln(sum0, 0), 13);
    chk("first_diff", ln(diff0, 0), 7);

    // table-driven single transactions
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(tv[k].a0, tv[k].b0, tv[k].a1, tv[k].b1, tv[k].sat);
      in_valid = 1;
      out_ready = 1;
      #1 chk($sformatf("v%0d_in_ready", k), int'(tv[k].sh ? in_ready1 : in_ready0), 1);
      @(posedge clk); #1 in_valid = 0;
      chk($sformatf("v%0d_latency1", k), int'(tv[k].sh ? out_valid1 : out_valid0), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", k), int'(tv[k].sh ? out_valid1 : out_valid0), 1);
      chk($sformatf("v%0d_sum0", k), ln(tv[k].sh ? sum1 : sum0, 0), tv[k].s0);
      chk($sformatf("v%0d_diff0", k), ln(tv[k].sh ? diff1 : diff0, 0), tv[k].d0);
      chk($sformatf("v%0d_sum1", k), ln(tv[k].sh ? sum1 : sum0, 1), tv[k].s1);
      chk($sformatf("v%0d_diff1", k), ln(tv[k].sh ? diff1 : diff0, 1), tv[k].d1);
      chk($sformatf("v%0d_flags", k), int'(tv[k].sh ? flag1 : flag0), tv[k].fl);
    end
    repeat (3) @(posedge clk);

    // backpressure stream of 10 transactions
    m1 = 0; m2 = 0; tx = 0; rx = 0; stall_seen = 0; stalled = 0; held = '0;
    for (int c = 0; c < 80 && rx < 10; c++) begin
      @(negedge clk);
      out_ready = pat[c % 6];
      in_valid = tx < 10;
      drive(tx * 10, tx, 0, 0, 0);
      #1;
      if (stalled) begin
        checks++;
        if (sum0 !== held) begin
          errs++;
          $display("FAIL bp_stable: got %h expected %h", sum0, held);
        end
      end
      chk($sformatf("bp_in_ready_c%0d", c), int'(in_ready0), int'(!m1 || !m2 || out_ready));
      chk($sformatf("bp_out_valid_c%0d", c), int'(out_valid0), int'(m2));
      if (out_valid0 && out_ready) begin
        chk($sformatf("bp_sum_%0d", rx), ln(sum0, 0), 11 * rx);
        chk($sformatf("bp_diff_%0d", rx), ln(diff0, 0), 9 * rx);
        rx++;
      end
      stalled = out_valid0 && !out_ready;
      held = sum0;
      if (!in_ready0) stall_seen++;
      s2a = !m2 || out_ready;
      s1a = !m1 || s2a;
      if (s2a) m2 = m1;
      if (s1a) m1 = in_valid;
      if (in_valid && in_ready0) tx++;
    end
    chk("bp_received", rx, 10);
    chk("bp_sent", tx, 10);
    chk("bp_stall_seen", int'(stall_seen > 0), 1);
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);

    // reset with two transactions in flight
    @(negedge clk);
    out_ready = 0;
    in_valid = 1;
    drive(40, 1, 0, 0, 0);
    @(negedge clk);
    drive(50, 2, 0, 0, 0);
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid_low", int'(out_valid0), 0);
    chk("mid_rst_in_ready_low", int'(in_ready0), 0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    #1 chk("mid_rst_sum_cleared", ln(sum0, 0), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("mid_rst_no_output_%0d", c), int'(out_valid0), 0);
    end
    @(negedge clk);
    drive(20, -5, 0, 0, 0);
    in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    chk("post_rst_latency1", int'(out_valid0), 0);
    @(posedge clk); #1;
    chk("post_rst_valid", int'(out_valid0), 1);
    chk("post_rst_sum", ln(sum0, 0), 15);
    chk("post_rst_diff", ln(diff0, 0), 25);
    @(posedge clk); #1;
    chk("post_rst_drained", int'(out_valid0), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
